riscv_mem_responder: RTL and testbench
======================================

# riscv_mem_responder

Memory-side responder for the single-cycle RISC-V core. It serves the core's instruction-fetch port (`inst_addr` → `inst`) and its 4-byte-lane data port (`mem_addr`, `mem_data_in`, `mem_write_en` → `mem_data_out`) from one byte-addressed array. When the core raises `halted`, a dump FSM streams a configured window of memory out over a valid/ready port so the bench can check final memory state. It sits beside `riscv_core` in the top level and is the only storage the core sees besides its register file.

## Interface

Parameters:
- `MEM_BYTES`, 65536: array size in bytes; power of two, ≥ 8.
- `DUMP_BASE`, 0: byte address of the first dumped word; multiple of 4.
- `DUMP_WORDS`, 16: number of 32-bit words dumped after halt; 0 allowed.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_b`  in  1  reset, asynchronous, active-low.
- `inst_addr`  in  32  fetch byte address.
- `inst`  out  32  fetched instruction, little-endian.
- `mem_addr`  in  32  data byte address of lane 0.
- `mem_data_in`  in  8×[0:3]  write data, lane i → byte `mem_addr+i`.
- `mem_write_en`  in  1  write strobe, all four lanes.
- `mem_data_out`  out  8×[0:3]  read data, lane i ← byte `mem_addr+i`.
- `halted`  in  1  core halt indication.
- `dump_valid`  out  1  dump word available.
- `dump_ready`  in  1  consumer accepts word.
- `dump_addr`  out  32  byte address of current dump word.
- `dump_data`  out  32  dump word, little-endian.
- `dump_done`  out  1  dump finished; sticky until reset.
- `addr_err`  out  1  sticky access-error flag.

## Operation

- Address mapping: byte address a selects array byte `a mod MEM_BYTES`, with wrap-around per lane. The upper address bits are ignored.
- Reads are combinational from current array contents:
  - `inst = {m[a+3], m[a+2], m[a+1], m[a]}` with a = `inst_addr`.
  - `mem_data_out[i] = m[mem_addr+i]`.
- Write: at a rising edge with `mem_write_en`=1 and state RUN, `m[mem_addr+i] <= mem_data_in[i]` for i = 0..3. In DUMP or DONE, writes are ignored.
- The array is not cleared by reset. Contents are preserved across reset and are preloaded by the bench.
- `addr_err` is set (sticky) at a rising edge in RUN when either condition holds:
  - `inst_addr[1:0] != 0`;
  - `mem_write_en`=1 and `mem_addr mod MEM_BYTES > MEM_BYTES-4` (a write that wraps).
  
  The access itself still executes with wrap. The flag clears only on reset.
- FSM states: RUN, DUMP, DONE. Word index k is `$clog2(DUMP_WORDS+1)` bits.
  - RUN: when `halted`=1 at a rising edge, go to DUMP (or to DONE if `DUMP_WORDS`=0), with k ← 0.
  - DUMP:
    - `dump_valid`=1, `dump_addr = DUMP_BASE + 4k` (32-bit wrap), `dump_data` = little-endian word at `dump_addr`.
    - On `dump_valid && dump_ready` at an edge: if k = `DUMP_WORDS-1`, go to DONE; else k ← k+1.
    - `halted` is ignored in this state.
  - DONE: `dump_valid`=0, `dump_done`=1. Stays until reset.
- Outputs must hold stable while `dump_valid`=1 and `dump_ready`=0.

## Timing

- Reset values: state RUN, k=0, `dump_valid`=0, `dump_done`=0, `addr_err`=0, `dump_addr`=`DUMP_BASE`, `dump_data` = word at `DUMP_BASE`. `inst` and `mem_data_out` reflect array contents (combinational).
- Read latency is 0 cycles. A write is visible on the read ports in the cycle after its edge.
- `halted` and `mem_write_en` at the same edge: the write is performed (state is still RUN), then DUMP begins. The dump reflects that write.
- First `dump_valid` appears the cycle after the edge that samples `halted`.
- With `dump_ready` held at 1: exactly `DUMP_WORDS` transfer cycles, and `dump_done`=1 in the following cycle.
- Reset asserted mid-dump: immediately returns to RUN with k=0 and `dump_valid`=0. Memory is unchanged.

## Test plan

- Preload `m[0..3]`=`13 05 a0 00`; `inst_addr`=0 → `inst`=`0x00a00513` in the same cycle.
- Write `mem_addr`=0x10, `mem_data_in`={`EF`,`BE`,`AD`,`DE`}, `mem_write_en` for 1 cycle. Next cycle, `mem_data_out` at 0x10 = {`EF`,`BE`,`AD`,`DE`}; `addr_err`=0.
- Write at `mem_addr`=`MEM_BYTES-2`, data {1,2,3,4} → bytes 1,2 land at the top of the array and 3,4 at 0 and 1; `addr_err`=1 the next cycle and stays 1.
- `DUMP_WORDS`=4, `DUMP_BASE`=0x10; raise `halted` with `dump_ready`=1 → four words at 0x10, 0x14, 0x18, 0x1C on consecutive cycles. Word 0 = `0xDEADBEEF`. `dump_done`=1 on the 5th cycle.
- Same dump with `dump_ready` toggling 1,0,0,1,…: `dump_addr`/`dump_data` hold during stalls, and exactly 4 transfers occur. A write attempted in DUMP leaves memory unchanged.
- Pull `rst_b` low after 2 dump transfers → `dump_valid`=0 and state RUN. Re-halting restarts the dump at `DUMP_BASE`, with contents intact.

Source files
------------

// File: rtl/riscv_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_responder
// Brief    : Byte-addressed memory serving the core's fetch and 4-lane data
//            ports, plus a post-halt dump engine streaming a fixed window of
//            memory over a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_mem_responder #(
   parameter int          MEM_BYTES  = 65536,
   parameter logic [31:0] DUMP_BASE  = 32'h0000_0000,
   parameter int          DUMP_WORDS = 16
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst,
   input  logic [31:0] mem_addr,
   input  logic [7:0]  mem_data_in  [0:3],
   input  logic        mem_write_en,
   output logic [7:0]  mem_data_out [0:3],
   input  logic        halted,
   output logic        dump_valid,
   input  logic        dump_ready,
   output logic [31:0] dump_addr,
   output logic [31:0] dump_data,
   output logic        dump_done,
   output logic        addr_err
);

   localparam int AW = $clog2(MEM_BYTES);
   // Word index is sized to hold DUMP_WORDS; a zero-word dump still needs a
   // one-bit register so the design elaborates.
   localparam int KW = (DUMP_WORDS > 0) ? $clog2(DUMP_WORDS + 1) : 1;
   localparam logic [KW-1:0] K_LAST     = KW'((DUMP_WORDS > 0) ? DUMP_WORDS - 1 : 0);
   // Highest lane-0 offset at which a 4-byte write does not wrap.
   localparam logic [AW-1:0] WRAP_LIMIT = AW'(MEM_BYTES - 4);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_DUMP = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic          addr_err_q, addr_err_d;

   logic [7:0]    mem_q [0:MEM_BYTES-1];

   logic [AW-1:0] inst_base;
   logic [AW-1:0] data_base;
   logic [AW-1:0] dump_base;
   logic [7:0]    inst_bytes [0:3];
   logic [7:0]    dump_bytes [0:3];
   logic          write_fire;
   logic          unused_addr_bits;

   // Upper address bits are dropped: the array aliases across the 32-bit space.
   assign inst_base        = inst_addr[AW-1:0];
   assign data_base        = mem_addr[AW-1:0];
   assign unused_addr_bits = ^{inst_addr[31:AW], mem_addr[31:AW]};

   // Dump word address advances by one word per accepted transfer.
   assign dump_addr = DUMP_BASE + (32'(k_q) << 2);
   assign dump_base = dump_addr[AW-1:0];

   // Memory is frozen once the core has halted so the dump sees a stable image.
   assign write_fire = mem_write_en && (state_q == ST_RUN);

   // Byte-lane writes into the shared array; no reset so contents survive rst_b.
   always_ff @(posedge clk) begin
      if (write_fire) begin
         for (int i = 0; i < 4; i++) begin
            mem_q[data_base + AW'(i)] <= mem_data_in[i];
         end
      end
   end

   // Zero-latency reads for fetch, data and dump ports, each lane wrapping.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         inst_bytes[i]   = mem_q[inst_base + AW'(i)];
         mem_data_out[i] = mem_q[data_base + AW'(i)];
         dump_bytes[i]   = mem_q[dump_base + AW'(i)];
      end
   end

   assign inst      = {inst_bytes[3], inst_bytes[2], inst_bytes[1], inst_bytes[0]};
   assign dump_data = {dump_bytes[3], dump_bytes[2], dump_bytes[1], dump_bytes[0]};
   assign addr_err  = addr_err_q;

   // State, word index and sticky error registers.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q    <= ST_RUN;
         k_q        <= '0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         addr_err_q <= addr_err_d;
      end
   end

   // Next-state, error detection and dump handshake outputs.
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      addr_err_d = addr_err_q;
      dump_valid = 1'b0;
      dump_done  = 1'b0;
      case (state_q)
         ST_RUN: begin
            // Misaligned fetch or a write that straddles the top of the array.
            if ((inst_addr[1:0] != 2'b00) ||
                (mem_write_en && (data_base > WRAP_LIMIT))) begin
               addr_err_d = 1'b1;
            end
            if (halted) begin
               k_d     = '0;
               state_d = (DUMP_WORDS == 0) ? ST_DONE : ST_DUMP;
            end
         end
         ST_DUMP: begin
            dump_valid = 1'b1;
            if (dump_ready) begin
               if (k_q == K_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
         end
         ST_DONE: begin
            dump_done = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_mem_responder
// Brief    : Directed bench for riscv_mem_responder with a byte-array /
//            queue reference model compared every cycle, plus literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_mem_responder;

   localparam int          MEMB = 256;
   localparam logic [31:0] BASE = 32'h0000_0010;
   localparam int          NW   = 4;

   logic        clk = 1'b0;
   logic        rst_b;
   logic [31:0] inst_addr;
   logic [31:0] inst;
   logic [31:0] mem_addr;
   logic [7:0]  mem_data_in  [0:3];
   logic        mem_write_en;
   logic [7:0]  mem_data_out [0:3];
   logic        halted;
   logic        dump_valid;
   logic        dump_ready;
   logic [31:0] dump_addr;
   logic [31:0] dump_data;
   logic        dump_done;
   logic        addr_err;

   int tests = 0;
   int fails = 0;

   riscv_mem_responder #(
      .MEM_BYTES (MEMB),
      .DUMP_BASE (BASE),
      .DUMP_WORDS(NW)
   ) dut (
      .clk         (clk),
      .rst_b       (rst_b),
      .inst_addr   (inst_addr),
      .inst        (inst),
      .mem_addr    (mem_addr),
      .mem_data_in (mem_data_in),
      .mem_write_en(mem_write_en),
      .mem_data_out(mem_data_out),
      .halted      (halted),
      .dump_valid  (dump_valid),
      .dump_ready  (dump_ready),
      .dump_addr   (dump_addr),
      .dump_data   (dump_data),
      .dump_done   (dump_done),
      .addr_err    (addr_err)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } ent_t;

   logic [7:0] mm [0:MEMB-1];
   bit         mk [0:MEMB-1];
   ent_t       mq [$];
   bit         m_dumping = 1'b0;
   bit         m_done    = 1'b0;
   bit         m_err     = 1'b0;

   function automatic logic [31:0] mword(input logic [31:0] a);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = mm[(a + 32'(i)) % MEMB];
      return w;
   endfunction

   function automatic bit mknown(input logic [31:0] a);
      bit k;
      k = 1'b1;
      for (int i = 0; i < 4; i++) k = k & mk[(a + 32'(i)) % MEMB];
      return k;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: memory updates only while running; halting snapshots the window
   // into a queue that the handshake drains.
   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         m_dumping = 1'b0;
         m_done    = 1'b0;
         m_err     = 1'b0;
         mq.delete();
      end else if (!m_dumping && !m_done) begin
         if (mem_write_en) begin
            if ((mem_addr % MEMB) > (MEMB - 4)) m_err = 1'b1;
            for (int i = 0; i < 4; i++) begin
               mm[(mem_addr + 32'(i)) % MEMB] = mem_data_in[i];
               mk[(mem_addr + 32'(i)) % MEMB] = 1'b1;
            end
         end
         if (inst_addr[1:0] != 2'b00) m_err = 1'b1;
         if (halted) begin
            for (int k = 0; k < NW; k++) begin
               mq.push_back('{a: BASE + 32'(4 * k), d: mword(BASE + 32'(4 * k))});
            end
            if (NW == 0) m_done = 1'b1;
            else         m_dumping = 1'b1;
         end
      end else if (m_dumping) begin
         if (dump_ready) begin
            void'(mq.pop_front());
            if (mq.size() == 0) begin
               m_dumping = 1'b0;
               m_done    = 1'b1;
            end
         end
      end
   end

   // Compare DUT against the model every cycle, mid-cycle.
   always @(negedge clk) begin
      chk("m_addr_err", 32'(addr_err), 32'(m_err));
      chk("m_dump_valid", 32'(dump_valid), 32'(m_dumping));
      chk("m_dump_done", 32'(dump_done), 32'(m_done));
      if (mknown(inst_addr)) chk("m_inst", inst, mword(inst_addr));
      if (mknown(mem_addr))
         chk("m_data_out", {mem_data_out[3], mem_data_out[2], mem_data_out[1], mem_data_out[0]},
             mword(mem_addr));
      if (m_dumping && mq.size() > 0) begin
         chk("m_dump_addr", dump_addr, mq[0].a);
         chk("m_dump_data", dump_data, mq[0].d);
      end else if (!m_dumping && !m_done) begin
         chk("m_run_dump_addr", dump_addr, BASE);
         if (mknown(BASE)) chk("m_run_dump_data", dump_data, mword(BASE));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic set_wr(input logic [31:0] a, input logic [31:0] w);
      mem_addr = a;
      for (int i = 0; i < 4; i++) mem_data_in[i] = w[8*i +: 8];
   endtask

   task automatic do_reset();
      rst_b = 1'b0;
      step();
      rst_b = 1'b1;
   endtask

   int pat [4] = '{1, 0, 0, 1};

   initial begin : p_watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : p_main
      int          xfers;
      bit          fin;
      logic [31:0] w;

      rst_b        = 1'b0;
      inst_addr    = 32'h0;
      mem_addr     = 32'h0;
      mem_write_en = 1'b0;
      halted       = 1'b0;
      dump_ready   = 1'b0;
      for (int i = 0; i < 4; i++) mem_data_in[i] = 8'h00;
      repeat (3) @(posedge clk);
      #2 rst_b = 1'b1;

      // Reset state
      sample();
      chk("rst_addr_err", 32'(addr_err), 32'h0);
      chk("rst_dump_valid", 32'(dump_valid), 32'h0);
      chk("rst_dump_done", 32'(dump_done), 32'h0);
      chk("rst_dump_addr", dump_addr, 32'h10);

      // Preload through the write port
      for (int a = 0; a < MEMB; a += 4) begin
         for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'((a + i) * 37 + 11);
         if (a == 0) w = 32'h00a00513;
         set_wr(32'(a), w);
         mem_write_en = 1'b1;
         step();
      end
      mem_write_en = 1'b0;
      inst_addr    = 32'h0;
      sample();
      chk("fetch0", inst, 32'h00a00513);

      // Single aligned write
      set_wr(32'h10, 32'hDEADBEEF);
      mem_write_en = 1'b1;
      step();
      mem_write_en = 1'b0;
      sample();
      chk("wr_word", {mem_data_out[3], mem_data_out[2], mem_data_out[1], mem_data_out[0]}, 32'hDEADBEEF);
      chk("wr_lane0", 32'(mem_data_out[0]), 32'hEF);
      chk("wr_no_err", 32'(addr_err), 32'h0);

      // Dump with ready held high
      dump_ready = 1'b1;
      halted     = 1'b1;
      step();
      halted = 1'b0;
      xfers  = 0;
      for (int c = 0; c < 4; c++) begin
         sample();
         chk("dump1_valid", 32'(dump_valid), 32'h1);
         chk("dump1_addr", dump_addr, 32'h10 + 32'(4 * c));
         if (c == 0) chk("dump1_word0", dump_data, 32'hDEADBEEF);
         if (dump_valid && dump_ready) xfers++;
         step();
      end
      sample();
      chk("dump1_done", 32'(dump_done), 32'h1);
      chk("dump1_valid_off", 32'(dump_valid), 32'h0);
      chk("dump1_xfers", 32'(xfers), 32'h4);

      // Wrapping write at the top of the array
      do_reset();
      sample();
      chk("rst2_done", 32'(dump_done), 32'h0);
      chk("rst2_err", 32'(addr_err), 32'h0);
      set_wr(32'(MEMB - 2), 32'h04030201);
      mem_write_en = 1'b1;
      step();
      mem_write_en = 1'b0;
      sample();
      chk("wrap_err", 32'(addr_err), 32'h1);
      chk("wrap_word", {mem_data_out[3], mem_data_out[2], mem_data_out[1], mem_data_out[0]}, 32'h04030201);
      chk("wrap_low_bytes", inst, 32'h00a00403);
      step();
      sample();
      chk("wrap_err_sticky", 32'(addr_err), 32'h1);

      // Misaligned fetch raises the flag
      do_reset();
      inst_addr = 32'h2;
      step();
      inst_addr = 32'h0;
      sample();
      chk("misalign_err", 32'(addr_err), 32'h1);

      // Dump with stalling consumer and a write attempt during the dump
      dump_ready = (pat[0] != 0);
      halted     = 1'b1;
      step();
      halted = 1'b0;
      set_wr(32'h10, 32'h0);
      mem_write_en = 1'b1;
      xfers = 0;
      fin   = 1'b0;
      for (int c = 0; c < 20 && !fin; c++) begin
         sample();
         if (dump_done) begin
            fin = 1'b1;
         end else begin
            if (dump_valid && dump_ready) xfers++;
            step();
            dump_ready = (pat[(c + 1) % 4] != 0);
         end
      end
      mem_write_en = 1'b0;
      chk("dump2_finished", 32'(fin), 32'h1);
      chk("dump2_xfers", 32'(xfers), 32'h4);
      mem_addr = 32'h10;
      sample();
      chk("dump2_wr_ignored", {mem_data_out[3], mem_data_out[2], mem_data_out[1], mem_data_out[0]},
          32'hDEADBEEF);

      // Reset in the middle of a dump, then dump again
      do_reset();
      halted     = 1'b1;
      dump_ready = 1'b1;
      step();
      halted = 1'b0;
      sample();
      step();
      sample();
      step();
      rst_b = 1'b0;
      #1;
      chk("midrst_valid", 32'(dump_valid), 32'h0);
      chk("midrst_addr", dump_addr, 32'h10);
      chk("midrst_done", 32'(dump_done), 32'h0);
      @(posedge clk);
      #2 rst_b = 1'b1;
      sample();
      chk("midrst_valid_after", 32'(dump_valid), 32'h0);
      halted = 1'b1;
      step();
      halted = 1'b0;
      sample();
      chk("redump_valid", 32'(dump_valid), 32'h1);
      chk("redump_addr", dump_addr, 32'h10);
      chk("redump_word0", dump_data, 32'hDEADBEEF);
      xfers = 0;
      fin   = 1'b0;
      for (int c = 0; c < 10 && !fin; c++) begin
         if (dump_done) begin
            fin = 1'b1;
         end else begin
            if (dump_valid && dump_ready) xfers++;
            step();
            sample();
         end
      end
      chk("redump_finished", 32'(fin), 32'h1);
      chk("redump_xfers", 32'(xfers), 32'h4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
